// File: rtl/param_lifo_pkg.sv
// Shared types and helpers for the parametrised LIFO stack.
// Operation decode is kept here so the top only sequences state.
package param_lifo_pkg;

    typedef enum logic [1:0] {
        OP_IDLE,
        OP_PUSH,
        OP_POP,
        OP_REPL
    } op_e;

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    // Rejected pushes/pops decode to OP_IDLE; a push+pop on an empty stack is a plain push.
    function automatic op_e decode_op(input logic psh, input logic pp,
                                      input logic is_empty, input logic is_full);
        op_e op;
        op = OP_IDLE;
        if (psh && pp) begin
            op = is_empty ? OP_PUSH : OP_REPL;
        end else if (psh) begin
            op = is_full ? OP_IDLE : OP_PUSH;
        end else if (pp) begin
            op = is_empty ? OP_IDLE : OP_POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/lifo_ram.sv
// Storage for the entries below top-of-stack: synchronous write, asynchronous read.
module lifo_ram
    import param_lifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [ADDRWIDTH-1:0] waddr_i,
    input  logic [DATAWIDTH-1:0] wdata_i,
    input  logic [ADDRWIDTH-1:0] raddr_i,
    output logic [DATAWIDTH-1:0] rdata_o
);

    localparam int unsigned DEPTH = depth_of(ADDRWIDTH);

    logic [DATAWIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/param_lifo_stack.sv
// Push-down stack with registered top-of-stack, replace-top, occupancy count,
// almost-full threshold and sticky overflow/underflow flags.
module param_lifo_stack
    import param_lifo_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4,
    parameter int unsigned AFULL_LVL = 14
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 En,
    input  logic                 push_i,
    input  logic                 pop_i,
    input  logic [DATAWIDTH-1:0] data_i,
    input  logic                 err_clr_i,
    output logic [DATAWIDTH-1:0] data_o,
    output logic [ADDRWIDTH:0]   count_o,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_full,
    output logic                 ovf_o,
    output logic                 udf_o
);

    localparam int unsigned DEPTH = depth_of(ADDRWIDTH);
    localparam int unsigned CW    = ADDRWIDTH + 1;

    logic [CW-1:0]        count_q, count_d;
    logic [DATAWIDTH-1:0] tos_q, tos_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 psh, pp;
    logic                 is_empty, is_full;
    op_e                  op;

    logic                 ram_we;
    logic [ADDRWIDTH-1:0] ram_waddr, ram_raddr;
    logic [DATAWIDTH-1:0] ram_rdata;

    assign psh      = En & push_i;
    assign pp       = En & pop_i;
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));
    assign op       = decode_op(psh, pp, is_empty, is_full);

    // Address arithmetic in ADDRWIDTH bits: at N==DEPTH the low bits are 0, so N-2 still lands on DEPTH-2.
    assign ram_waddr = count_q[ADDRWIDTH-1:0] - ADDRWIDTH'(1);
    assign ram_raddr = count_q[ADDRWIDTH-1:0] - ADDRWIDTH'(2);
    assign ram_we    = ~Rst & (op == OP_PUSH) & ~is_empty;

    lifo_ram #(
        .DATAWIDTH(DATAWIDTH),
        .ADDRWIDTH(ADDRWIDTH)
    ) u_ram (
        .clk_i  (Clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(tos_q),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        count_d = count_q;
        tos_d   = tos_q;
        unique case (op)
            OP_PUSH: begin
                count_d = count_q + CW'(1);
                tos_d   = data_i;
            end
            OP_POP: begin
                count_d = count_q - CW'(1);
                tos_d   = (count_q == CW'(1)) ? '0 : ram_rdata;
            end
            OP_REPL: tos_d = data_i;
            default: ;
        endcase
        // A fresh error in the same cycle as a clear leaves the flag set.
        ovf_d = (ovf_q & ~err_clr_i) | (psh & ~pp & is_full);
        udf_d = (udf_q & ~err_clr_i) | (pp & ~psh & is_empty);
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            count_q <= '0;
            tos_q   <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tos_q   <= tos_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign data_o      = tos_q;
    assign count_o     = count_q;
    assign empty       = is_empty;
    assign full        = is_full;
    assign almost_full = (count_q >= CW'(AFULL_LVL));
    assign ovf_o       = ovf_q;
    assign udf_o       = udf_q;

endmodule

// File: doc/param_lifo_stack.md
Name: param_lifo_stack

Overview:
Parametrised push-down (LIFO) stack, the successor to the team's fixed-width stack. Adds a registered top-of-stack peek output, simultaneous push+pop (replace-top), an occupancy count, an almost-full threshold, and sticky overflow/underflow error flags. It sits between a producer and a consumer that share one clock.

Parameters:
DATAWIDTH, 8, entry width in bits
ADDRWIDTH, 4, storage address width; DEPTH = 2**ADDRWIDTH entries (16 by default)
AFULL_LVL, 14, count at or above which almost_full asserts (legal range 1..DEPTH)

Ports:
Clk  in  1  clock; all state updates on the rising edge
Rst  in  1  synchronous, active-high reset
En  in  1  operation enable; when 0, push_i and pop_i are ignored
push_i  in  1  push request
pop_i  in  1  pop request
data_i  in  DATAWIDTH  data to push
err_clr_i  in  1  clears ovf_o and udf_o
data_o  out  DATAWIDTH  current top-of-stack value; 0 when empty
count_o  out  ADDRWIDTH+1  number of stored entries, 0..DEPTH
empty  out  1  count_o == 0
full  out  1  count_o == DEPTH
almost_full  out  1  count_o >= AFULL_LVL
ovf_o  out  1  sticky: a push was rejected because the stack was full
udf_o  out  1  sticky: a pop was rejected because the stack was empty

Behaviour:
- Reset (Rst=1 at a clock edge; overrides every other input that cycle):
  - count_o=0, data_o=0, empty=1, full=0, almost_full=0, ovf_o=0, udf_o=0.
  - Storage contents are not cleared.
- Storage split:
  - TOS register holds the top entry and drives data_o directly, with no combinational path from inputs.
  - The RAM holds entries below the top; RAM index k stores the entry at depth k+1 from the bottom.
  - The RAM has a synchronous write and an asynchronous read.
- Flags empty, full and almost_full are decoded from registered count_o; there is no combinational path from push_i or pop_i.
- Effective requests: psh = En & push_i; pp = En & pop_i. Per cycle, with N = count_o:
  - Idle (psh=0, pp=0): no change.
  - Push only, N<DEPTH: if N>0, RAM[N-1] <= TOS. Then TOS <= data_i and N <= N+1. data_o shows data_i the next cycle (latency 1).
  - Push only, N==DEPTH: rejected. State is unchanged and ovf_o <= 1.
  - Pop only, N>0: N <= N-1. TOS <= RAM[N-2] if N>=2, else TOS <= 0. Next cycle data_o shows the new top.
  - Pop only, N==0: rejected. State is unchanged and udf_o <= 1.
  - Push+pop, N>0: replace-top. TOS <= data_i, N is unchanged, the RAM is not written, and no flag is set. This holds at N==DEPTH too.
  - Push+pop, N==0: executes as push only. N <= 1 and udf_o is not set.
- Sticky error flags:
  - ovf_o and udf_o stay set until err_clr_i=1 or Rst.
  - If err_clr_i and a new error occur in the same cycle, the flag ends set (the new error wins).
  - err_clr_i is not gated by En.
- count_o never wraps: it saturates at 0 and at DEPTH through the rejection rules above.
- RAM capacity is DEPTH-1 entries, because the top entry lives in TOS. A RAM sized at DEPTH entries is acceptable, but index DEPTH-1 is never written.
- X-safety: data_i is not sampled unless an accepted push or replace occurs.

Decomposition:
- Package param_lifo_pkg:
  - op encoding typedef {OP_IDLE, OP_PUSH, OP_POP, OP_REPL}, decoded from psh/pp/N.
  - Helper function depth_of(ADDRWIDTH).
- One sub-module, lifo_ram: parametrised DATAWIDTH × 2**ADDRWIDTH array with synchronous write and asynchronous read.
- The top level holds the op decode, the TOS register, the count register, flag decode and the sticky error logic.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles -> count_o=3 and data_o=0x33; then pop 3 times -> data_o steps 0x22, 0x11, 0x00 and empty=1.
- Fill 16 pushes of values 0x00..0x0F -> full=1, count_o=16, data_o=0x0F, almost_full=1 from count 14; a 17th push with data_i=0xAA -> count_o=16, data_o=0x0F, ovf_o=1.
- Pop on empty after reset -> udf_o=1, count_o=0; then err_clr_i=1 for one cycle -> udf_o=0; err_clr_i together with another empty pop -> udf_o stays 1.
- Push 0x5A, then push+pop with data_i=0xC3 -> count_o=1, data_o=0xC3; push+pop on empty with data_i=0x77 -> count_o=1, data_o=0x77, udf_o=0.
- With En=0, push_i=1 and pop_i=1 for 5 cycles -> no state change and no flags; Rst=1 asserted while push_i=1 at count 5 -> next cycle count_o=0, data_o=0, flags cleared.
- Random push/pop/replace sequence of 2000 cycles against a reference queue model -> data_o, count_o and all flags match every cycle.
